e_muldiv_unit: RTL and testbench
================================

Name: e_muldiv_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the operand values and decoded operation carried into E by the D/E pipeline register.
- Returns `busy` to the hazard unit, which then stalls D and clears E for any following MULT/DIV/MFHI/MFLO/MTHI/MTLO.
- Supplies HI/LO to the E-stage result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, cycles from start until a MULT/MULTU result is visible on hi/lo (range 1..31)
- DIV_CYCLES, 10, cycles from start until a DIV/DIVU result is visible on hi/lo (range 1..31)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is a muldiv op (already qualified: 0 for bubbles)
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
- rs  input  32  forwarded RD1 value in E
- rt  input  32  forwarded RD2 value in E
- busy  output  1  operation in flight; HI/LO not yet valid
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result=0. Takes effect mid-operation: the in-flight op is abandoned and no result is written.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter decrementing).
- IDLE, start=1, op in {0..3}:
  - At this edge, latch the computed 64-bit pending {hi,lo} result.
  - Load counter with N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- RUN:
  - Each edge, counter decrements.
  - At the edge where counter==0: hi/lo load the pending result, busy drops to 0, return to IDLE.
  - An op started at edge T has its result visible on hi/lo after edge T+N; busy is high during cycles T+1..T+N.
  - hi/lo keep their old values while busy.
- IDLE, start=1, op=4: hi<=rs at this edge. op=5: lo<=rs at this edge. busy stays 0.
- start=1 while busy=1: ignored entirely, whatever the op. The hazard unit guarantees this does not occur. The bench checks the ignore behaviour.
- Reserved op with start=1: no effect.
- MULT:
  - Signed 32x32 product; {hi,lo} = 64-bit result.
  - MULTU is the same with unsigned operands.
- DIV:
  - Signed division; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU is the same with unsigned operands.
- Divide by zero (rt==0, DIV or DIVU): the op still runs DIV_CYCLES with busy, but hi/lo are left unchanged at completion.
- Signed overflow (DIV, rs=0x80000000, rt=0xFFFFFFFF): lo=0x80000000, hi=0x00000000.
- Results are computed combinationally at start and held in pending registers. The cycle count is purely a timing model, and rs/rt may change after the start cycle.

Decomposition:
- Shared package (muldiv_defs): op encodings OP_MULT..OP_MTLO, counter width (5 bits), default cycle counts.
- One sub-module, muldiv_arith: combinational signed/unsigned multiply and divide.
  - Produces the 64-bit {hi,lo} result plus a div_zero flag.
  - Handles the overflow case explicitly.

Test Plan:
- Reset then idle -> hi=0, lo=0, busy=0. Assert reset=0 during RUN -> busy=0 and hi/lo=0 immediately, with no later write.
- MULT rs=0xFFFFFFFE (-2), rt=3 at edge T -> busy=1 in cycles T+1..T+5; after edge T+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU x/0 after MTHI 0x1234, MTLO 0x5678 -> busy for 10 cycles; then hi=0x1234, lo=0x5678 unchanged.
- MTHI rs=0xAAAA5555 in IDLE -> hi updated after 1 edge, busy never asserts. MTLO issued while a MULT is busy -> ignored; lo after completion equals the MULT result.
- Second MULT with start=1 during RUN of a DIV -> ignored; completion timing and result match the DIV alone. Back-to-back start in the first IDLE cycle after completion -> accepted.

Source files
------------

// File: rtl/e_muldiv_unit_pkg.sv
// Purpose: shared op encodings, counter width and default timing for the E-stage muldiv unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package muldiv_defs;

  localparam int CNT_W = 5;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that occupy the unit for a multi-cycle timing window.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_muldiv_unit_if.sv
// Purpose: bundles the E-stage muldiv request (start/op/operands) and the HI/LO/busy response.
// Latency: n/a (wires only).
// Backpressure: busy tells the hazard unit to hold off further muldiv ops.
interface e_muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs, rt, input busy, hi, lo);
  modport slave  (input start, op, rs, rt, output busy, hi, lo);
endinterface

// File: rtl/e_muldiv_unit_arith.sv
// Purpose: combinational signed/unsigned 32x32 multiply and divide producing {hi,lo}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module muldiv_arith
  import muldiv_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Multiply and divide on magnitudes; signs are restored afterwards so that the
  // quotient truncates toward zero and the remainder follows the dividend.
  always_comb begin
    prod_s     = '0;
    prod_u     = '0;
    signed_div = 1'b0;
    a_mag      = '0;
    b_mag      = '0;
    b_safe     = 32'd1;
    q_mag      = '0;
    r_mag      = '0;
    quot       = '0;
    rem        = '0;
    result     = '0;
    div_zero   = 1'b0;

    prod_s = 64'($signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt}));
    prod_u = {32'd0, rs} * {32'd0, rt};

    signed_div = (op == OP_DIV);
    a_mag      = (signed_div && rs[31]) ? (32'd0 - rs) : rs;
    b_mag      = (signed_div && rt[31]) ? (32'd0 - rt) : rt;
    // A zero divisor never reaches HI/LO, so any non-zero stand-in keeps the divider defined.
    b_safe     = (rt == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (signed_div && (rs[31] ^ rt[31])) ? (32'd0 - q_mag) : q_mag;
    rem        = (signed_div && rs[31]) ? (32'd0 - r_mag) : r_mag;

    // Most-negative / -1 does not fit; pin it to the wrapped quotient and zero remainder.
    if (signed_div && (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF)) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end

    case (op)
      OP_MULT:          result = prod_s;
      OP_MULTU:         result = prod_u;
      OP_DIV, OP_DIVU:  result = {rem, quot};
      default:          result = '0;
    endcase

    div_zero = is_div(op) && (rt == 32'd0);
  end

endmodule

// File: rtl/e_muldiv_unit.sv
// Purpose: E-stage multiply/divide unit owning the architectural HI/LO registers.
// Latency: MULT/MULTU MULT_CYCLES, DIV/DIVU DIV_CYCLES, MTHI/MTLO 1 edge.
// Backpressure: busy high while an op is in flight; any start seen while busy is dropped.
module e_muldiv_unit
  import muldiv_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  e_muldiv_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      pend_q;
  logic             pend_dz_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      arith_res;
  logic             arith_dz;
  logic             accept_md;
  logic             idle_start;
  logic             done;

  muldiv_arith u_arith (
    .op       (bus.op),
    .rs       (bus.rs),
    .rt       (bus.rt),
    .result   (arith_res),
    .div_zero (arith_dz)
  );

  assign idle_start = (state_q == ST_IDLE) && bus.start;
  assign accept_md  = idle_start && is_muldiv(bus.op);

  // Next-state: leave IDLE on an accepted mul/div, return when the countdown expires.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_md) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the result at start (operands may change afterwards) and run the timing countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
    end else if (accept_md) begin
      cnt_q     <= is_div(bus.op) ? DIV_LOAD : MULT_LOAD;
      pend_q    <= arith_res;
      pend_dz_q <= arith_dz;
    end else if ((state_q == ST_RUN) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // HI/LO: commit the pending result on completion (skipped on divide by zero), or direct moves in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      if (!pend_dz_q) begin
        hi_q <= pend_q[63:32];
        lo_q <= pend_q[31:0];
      end
    end else if (idle_start && (bus.op == OP_MTHI)) begin
      hi_q <= bus.rs;
    end else if (idle_start && (bus.op == OP_MTLO)) begin
      lo_q <= bus.rs;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Purpose: directed self-checking bench for e_muldiv_unit (vector table plus multi-cycle corner sequences).
// Latency: expects MULT ops to take 5 cycles and DIV ops 10.
// Backpressure: exercises starts issued while busy.
module tb_e_muldiv_unit;
  import muldiv_defs::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  localparam int NV = 15;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;
  vec_t vecs [NV];

  e_muldiv_unit_if bus ();

  e_muldiv_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; drives start for exactly one posedge, returns at the following negedge.
  task automatic do_start(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = rs;
    bus.rt    = rt;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom_range(0, 7));
    bus.rs    = $urandom;
    bus.rt    = $urandom;
  endtask

  // Counts negedge samples with busy high, bounded so a stuck unit cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.rs    = '0;
    bus.rt    = '0;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         10};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[5]  = '{OP_MTHI,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'h8000_0000, 0};
    vecs[6]  = '{OP_MTLO,  32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0};
    vecs[7]  = '{OP_DIVU,  32'd9,         32'd0,         32'h0000_1234, 32'h0000_5678, 10};
    vecs[8]  = '{OP_DIV,   32'd5,         32'd0,         32'h0000_1234, 32'h0000_5678, 10};
    vecs[9]  = '{OP_MTHI,  32'hAAAA_5555, 32'd0,         32'hAAAA_5555, 32'h0000_5678, 0};
    vecs[10] = '{3'd6,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_5555, 32'h0000_5678, 0};
    vecs[11] = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[12] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[13] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[14] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, 10};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      do_start(vecs[i].op, vecs[i].rs, vecs[i].rt);
      if (vecs[i].exp_cyc > 0) begin
        chk($sformatf("v%0d_hold_hi", i), bus.hi, cur_hi);
        chk($sformatf("v%0d_hold_lo", i), bus.lo, cur_lo);
      end
      wait_idle(n);
      chk($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
      cur_hi = vecs[i].exp_hi;
      cur_lo = vecs[i].exp_lo;
    end

    // MTLO while a MULT is busy is dropped
    do_start(OP_MULT, 32'd6, 32'd7);
    bus.start = 1'b1;
    bus.op    = OP_MTLO;
    bus.rs    = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(n);
    chk("mtlo_busy_cycles", 32'(n + 1), 32'd5);
    chk("mtlo_busy_hi", bus.hi, 32'd0);
    chk("mtlo_busy_lo", bus.lo, 32'h0000_002A);

    // MULT during a DIV run is dropped; DIV timing and result are unaffected
    do_start(OP_DIV, 32'd100, 32'd7);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.rs    = 32'd3;
    bus.rt    = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(n);
    chk("mult_in_div_cycles", 32'(n + 1), 32'd10);
    chk("mult_in_div_hi", bus.hi, 32'd2);
    chk("mult_in_div_lo", bus.lo, 32'd14);

    // Back-to-back: start in the first idle cycle after completion is accepted
    do_start(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_idle(n);
    chk("b2b_cycles", 32'(n), 32'd5);
    chk("b2b_hi", bus.hi, 32'd1);
    chk("b2b_lo", bus.lo, 32'd0);

    // Reset mid-run: immediate clear, and the abandoned op never writes back
    do_start(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("postrst_busy", 32'(bus.busy), 32'd0);
    chk("postrst_hi", bus.hi, 32'd0);
    chk("postrst_lo", bus.lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
